duty_ramp_multi: RTL and testbench

- Multi-channel successor to the single-channel duty ramp controller. Each channel ramps an integer duty level from its current value up to MAX_DUTY in fixed time steps. It then holds for a fixed time and signals completion.
- On request, a channel ramps down to 0 and signals completion.
- New over the previous generation: parametrised channel count, width and periods; independent channels; mid-ramp reversal; no forced drop to 0 after the up-ramp.
- Drives PWM comparators downstream.

---
 rtl/duty_ramp_pkg.sv | 33 +++
 rtl/duty_ramp_ch.sv | 113 +++++++++++
 rtl/duty_ramp_multi.sv | 51 +++++
 tb/tb_duty_ramp_multi.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/duty_ramp_pkg.sv
// Shared types, defaults and parameter legality helper for the multi-channel duty ramp.
package duty_ramp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        UP   = 2'd1,
        HOLD = 2'd2,
        DOWN = 2'd3
    } ramp_state_e;

    localparam int DEF_NCH         = 4;
    localparam int DEF_DW          = 4;
    localparam int DEF_MAX_DUTY    = 10;
    localparam int DEF_PW          = 14;
    localparam int DEF_UP_PERIOD   = 70;
    localparam int DEF_DOWN_PERIOD = 175;
    localparam int DEF_HOLD_PERIOD = 1776;

    function automatic bit params_ok(input int nch, input int dw, input int max_duty,
                                     input int pw, input int up_p, input int dn_p,
                                     input int hold_p);
        longint lim_d;
        longint lim_p;
        lim_d = longint'(1) << dw;
        lim_p = longint'(1) << pw;
        return (nch >= 1) && (dw >= 1) && (pw >= 1) &&
               (max_duty >= 1) && (longint'(max_duty) < lim_d) &&
               (up_p >= 1) && (dn_p >= 1) && (hold_p >= 1) &&
               (longint'(up_p) <= lim_p) && (longint'(dn_p) <= lim_p) &&
               (longint'(hold_p) <= lim_p);
    endfunction

endpackage

// File: rtl/duty_ramp_ch.sv
// One duty ramp channel: request edge detect, IDLE/UP/HOLD/DOWN FSM, step timer, duty register.
module duty_ramp_ch
    import duty_ramp_pkg::*;
#(
    parameter int DW          = DEF_DW,
    parameter int MAX_DUTY    = DEF_MAX_DUTY,
    parameter int PW          = DEF_PW,
    parameter int UP_PERIOD   = DEF_UP_PERIOD,
    parameter int DOWN_PERIOD = DEF_DOWN_PERIOD,
    parameter int HOLD_PERIOD = DEF_HOLD_PERIOD
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_up,
    input  logic          down,
    output logic [DW-1:0] duty,
    output logic          ready,
    output logic          ready_d,
    output logic          busy
);

    localparam logic [PW-1:0] UP_LD   = PW'(UP_PERIOD - 1);
    localparam logic [PW-1:0] DN_LD   = PW'(DOWN_PERIOD - 1);
    localparam logic [PW-1:0] HOLD_LD = PW'(HOLD_PERIOD - 1);
    localparam logic [DW-1:0] MAX_D   = DW'(MAX_DUTY);

    ramp_state_e   st, st_n;
    logic [PW-1:0] tmr, tmr_n;
    logic [DW-1:0] duty_n, duty_inc, duty_dec;
    logic          prev_up, prev_dn, up_e, dn_e, expired;
    logic          ready_n, ready_d_n;

    assign up_e     = start_up & ~prev_up;
    assign dn_e     = down & ~prev_dn;
    assign expired  = (tmr == '0);
    assign duty_inc = duty + DW'(1);
    assign duty_dec = duty - DW'(1);
    assign busy     = (st != IDLE);

    always_comb begin
        st_n      = st;
        tmr_n     = tmr;
        duty_n    = duty;
        ready_n   = 1'b0;
        ready_d_n = 1'b0;
        case (st)
            IDLE: begin
                if (up_e) begin
                    if (duty < MAX_D) begin st_n = UP;   tmr_n = UP_LD;   end
                    else              begin st_n = HOLD; tmr_n = HOLD_LD; end
                end else if (dn_e && duty != '0) begin
                    st_n  = DOWN;
                    tmr_n = DN_LD;
                end
            end
            UP, HOLD: begin
                if (dn_e) begin
                    // Reversal straight after leaving 0 has nothing to ramp down; no pulse.
                    if (duty != '0) begin st_n = DOWN; tmr_n = DN_LD; end
                    else            begin st_n = IDLE; tmr_n = DN_LD; end
                end else if (!expired) begin
                    tmr_n = tmr - PW'(1);
                end else if (st == UP) begin
                    duty_n = duty_inc;
                    tmr_n  = UP_LD;
                    if (duty_inc == MAX_D) begin st_n = HOLD; tmr_n = HOLD_LD; end
                end else begin
                    ready_n = 1'b1;
                    st_n    = IDLE;
                    tmr_n   = HOLD_LD;
                end
            end
            DOWN: begin
                if (up_e) begin
                    // Reversal before the first down step is already at MAX: hold, never overshoot.
                    if (duty < MAX_D) begin st_n = UP;   tmr_n = UP_LD;   end
                    else              begin st_n = HOLD; tmr_n = HOLD_LD; end
                end else if (!expired) begin
                    tmr_n = tmr - PW'(1);
                end else begin
                    duty_n = duty_dec;
                    tmr_n  = DN_LD;
                    if (duty_dec == '0) begin
                        ready_d_n = 1'b1;
                        st_n      = IDLE;
                    end
                end
            end
            default: st_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st      <= IDLE;
            tmr     <= '0;
            duty    <= '0;
            ready   <= 1'b0;
            ready_d <= 1'b0;
            prev_up <= 1'b0;
            prev_dn <= 1'b0;
        end else begin
            st      <= st_n;
            tmr     <= tmr_n;
            duty    <= duty_n;
            ready   <= ready_n;
            ready_d <= ready_d_n;
            prev_up <= start_up;
            prev_dn <= down;
        end
    end

endmodule

// File: rtl/duty_ramp_multi.sv
// NCH independent duty ramp channels; the top only fans requests out and packs the results.
module duty_ramp_multi
    import duty_ramp_pkg::*;
#(
    parameter int NCH         = DEF_NCH,
    parameter int DW          = DEF_DW,
    parameter int MAX_DUTY    = DEF_MAX_DUTY,
    parameter int PW          = DEF_PW,
    parameter int UP_PERIOD   = DEF_UP_PERIOD,
    parameter int DOWN_PERIOD = DEF_DOWN_PERIOD,
    parameter int HOLD_PERIOD = DEF_HOLD_PERIOD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    start_up,
    input  logic [NCH-1:0]    down,
    output logic [NCH*DW-1:0] duty_cycle,
    output logic [NCH-1:0]    ready,
    output logic [NCH-1:0]    ready_d,
    output logic [NCH-1:0]    busy
);

    if (!params_ok(NCH, DW, MAX_DUTY, PW, UP_PERIOD, DOWN_PERIOD, HOLD_PERIOD)) begin : g_bad_params
        $error("duty_ramp_multi: illegal parameter combination");
    end

    logic [NCH-1:0][DW-1:0] duty_arr;

    assign duty_cycle = duty_arr;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        duty_ramp_ch #(
            .DW          (DW),
            .MAX_DUTY    (MAX_DUTY),
            .PW          (PW),
            .UP_PERIOD   (UP_PERIOD),
            .DOWN_PERIOD (DOWN_PERIOD),
            .HOLD_PERIOD (HOLD_PERIOD)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .start_up (start_up[i]),
            .down     (down[i]),
            .duty     (duty_arr[i]),
            .ready    (ready[i]),
            .ready_d  (ready_d[i]),
            .busy     (busy[i])
        );
    end

endmodule

// File: tb/tb_duty_ramp_multi.sv
// Scoreboard bench: stimulus queues hand-computed duty steps and pulses; a negedge monitor pops and compares.
module tb_duty_ramp_multi;

    localparam int NCH = 2;
    localparam int DW  = 4;
    localparam int K_DUTY = 0, K_RDY = 1, K_RDYD = 2;

    typedef struct {
        int kind;
        int val;
        int cyc;
    } ev_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NCH-1:0]    start_up = '0;
    logic [NCH-1:0]    down = '0;
    logic [NCH*DW-1:0] duty_cycle;
    logic [NCH-1:0]    ready, ready_d, busy;

    int  cyc = 0;
    int  n_chk = 0;
    int  n_pass = 0;
    ev_t sbq[NCH][$];

    duty_ramp_multi #(
        .NCH(NCH), .DW(DW), .MAX_DUTY(10), .PW(14),
        .UP_PERIOD(3), .DOWN_PERIOD(5), .HOLD_PERIOD(4)
    ) dut (
        .clk(clk), .rst(rst), .start_up(start_up), .down(down),
        .duty_cycle(duty_cycle), .ready(ready), .ready_d(ready_d), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int ch, input int kind, input int val, input int c);
        ev_t e;
        e.kind = kind; e.val = val; e.cyc = c;
        sbq[ch].push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
    endtask

    task automatic sb_check(input int ch, input int kind, input int val);
        ev_t e;
        n_chk++;
        if (sbq[ch].size() == 0) begin
            $display("FAIL sb_unexpected ch%0d at cycle %0d: got kind=%0d val=%0d, expected no event",
                     ch, cyc, kind, val);
        end else begin
            e = sbq[ch].pop_front();
            if (e.kind == kind && e.val == val && e.cyc == cyc) n_pass++;
            else $display("FAIL sb_event ch%0d: got kind=%0d val=%0d cycle=%0d, expected kind=%0d val=%0d cycle=%0d",
                          ch, kind, val, cyc, e.kind, e.val, e.cyc);
        end
    endtask

    // Edge index c has been taken once cyc==c at a falling edge.
    task automatic at(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    function automatic int duty_of(input int ch);
        logic [NCH*DW-1:0] v;
        v = duty_cycle;
        return int'(v[ch*DW +: DW]);
    endfunction

    // Monitor: every duty change and every pulse is one scoreboard event.
    initial begin
        int prev_duty[NCH];
        int d;
        for (int ch = 0; ch < NCH; ch++) prev_duty[ch] = 0;
        forever begin
            @(negedge clk);
            for (int ch = 0; ch < NCH; ch++) begin
                d = duty_of(ch);
                if (d != prev_duty[ch]) sb_check(ch, K_DUTY, d);
                prev_duty[ch] = d;
                if (ready[ch])   sb_check(ch, K_RDY, 1);
                if (ready_d[ch]) sb_check(ch, K_RDYD, 1);
            end
        end
    end

    initial begin
        int b;
        repeat (3) @(negedge clk);
        chk("reset_duty", int'(duty_cycle), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ready", int'({ready, ready_d}), 0);
        rst = 1'b0;
        @(negedge clk);

        // Full up-ramp on ch0
        b = cyc + 1;
        start_up[0] = 1'b1;
        for (int k = 1; k <= 10; k++) push(0, K_DUTY, k, b + 3 * k);
        push(0, K_RDY, 1, b + 34);
        at(b); start_up[0] = 1'b0;
        chk("s1_busy_on", int'(busy[0]), 1);
        at(b + 33); chk("s1_busy_hold", int'(busy[0]), 1);
        at(b + 34); chk("s1_busy_off", int'(busy[0]), 0);
        at(b + 36); chk("s1_duty_kept", duty_of(0), 10);

        // Full down-ramp on ch0
        b = cyc + 1;
        down[0] = 1'b1;
        for (int k = 1; k <= 10; k++) push(0, K_DUTY, 10 - k, b + 5 * k);
        push(0, K_RDYD, 1, b + 50);
        at(b); down[0] = 1'b0;
        chk("s2_busy_on", int'(busy[0]), 1);
        at(b + 50); chk("s2_busy_off", int'(busy[0]), 0);
        at(b + 52);

        // Bring ch1 to MAX
        b = cyc + 1;
        start_up[1] = 1'b1;
        for (int k = 1; k <= 10; k++) push(1, K_DUTY, k, b + 3 * k);
        push(1, K_RDY, 1, b + 34);
        at(b); start_up[1] = 1'b0;
        at(b + 36);

        // Concurrent: ch0 up, ch1 down
        b = cyc + 1;
        start_up[0] = 1'b1;
        down[1] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            push(0, K_DUTY, k, b + 3 * k);
            push(1, K_DUTY, 10 - k, b + 5 * k);
        end
        push(0, K_RDY, 1, b + 34);
        push(1, K_RDYD, 1, b + 50);
        at(b); start_up[0] = 1'b0; down[1] = 1'b0;
        chk("s6_busy_both", int'(busy), 3);
        at(b + 52);

        // Up-ramp reversed mid-way on ch1
        b = cyc + 1;
        start_up[1] = 1'b1;
        for (int k = 1; k <= 4; k++) push(1, K_DUTY, k, b + 3 * k);
        for (int k = 1; k <= 4; k++) push(1, K_DUTY, 4 - k, b + 13 + 5 * k);
        push(1, K_RDYD, 1, b + 33);
        at(b); start_up[1] = 1'b0;
        at(b + 12); down[1] = 1'b1;
        at(b + 13); down[1] = 1'b0;
        at(b + 35);

        // Down-ramp reversed on ch0 from MAX
        b = cyc + 1;
        down[0] = 1'b1;
        push(0, K_DUTY, 9, b + 5);
        push(0, K_DUTY, 8, b + 10);
        push(0, K_DUTY, 9, b + 15);
        push(0, K_DUTY, 10, b + 18);
        push(0, K_RDY, 1, b + 22);
        at(b); down[0] = 1'b0;
        at(b + 11); start_up[0] = 1'b1;
        at(b + 12); start_up[0] = 1'b0;
        at(b + 24);

        // Down request at duty 0 on ch1 is ignored
        b = cyc + 1;
        down[1] = 1'b1;
        at(b); down[1] = 1'b0;
        chk("s4_dn0_busy", int'(busy[1]), 0);
        at(b + 3); chk("s4_dn0_busy_late", int'(busy[1]), 0);

        // Up and down together in IDLE, then reset mid-ramp with requests held high
        b = cyc + 1;
        start_up[1] = 1'b1;
        down[1] = 1'b1;
        for (int k = 1; k <= 6; k++) push(1, K_DUTY, k, b + 3 * k);
        push(0, K_DUTY, 0, b + 20);
        push(1, K_DUTY, 0, b + 20);
        for (int k = 1; k <= 10; k++) push(1, K_DUTY, k, b + 21 + 3 * k);
        push(1, K_RDY, 1, b + 55);
        at(b); chk("s4_both_busy", int'(busy[1]), 1);
        at(b + 19); rst = 1'b1;
        at(b + 20); rst = 1'b0;
        chk("s5_rst_duty", int'(duty_cycle), 0);
        chk("s5_rst_busy", int'(busy), 0);
        chk("s5_rst_pulses", int'({ready, ready_d}), 0);
        at(b + 21); chk("s5_restart_busy", int'(busy[1]), 1);
        start_up[1] = 1'b0;
        down[1] = 1'b0;
        at(b + 58);
        chk("s5_final_duty", duty_of(1), 10);

        for (int ch = 0; ch < NCH; ch++) chk($sformatf("sb_drain_ch%0d", ch), sbq[ch].size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
